// File: rtl/arm_balance_n.sv
// arm_balance_n: N-cell full-bridge arm balancer for a modular multilevel
// converter arm. On each period strobe it snapshots the cell voltages, ranks
// the cells one pivot per cycle, and then selects the cells to insert (+vc or
// -vc) or bypass, based on the requested arm level and the current sign.
// Cells with equal voltage are ranked by a rotating key, so that over
// successive periods a different cell is preferred each time.
module arm_balance_n #(
    parameter int N  = 4,
    parameter int VW = 8,
    parameter int LW = $clog2(2*N+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            period_flag,
    input  logic            sign_i,
    input  logic [LW-1:0]   vc_level,
    input  logic [N*VW-1:0] vc_flat,
    output logic [2*N-1:0]  fo,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            overrun
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0]        LAST  = RW'(N-1);
    localparam logic [LW-1:0]        LMAX  = LW'(2*N);
    localparam logic signed [LW:0]   N_S   = (LW+1)'(N);

    typedef enum logic [1:0] {IDLE, RANK, APPLY} state_t;

    state_t               state, state_next;
    logic [VW-1:0]        vs   [N];
    logic [RW-1:0]        rank [N];
    logic [RW-1:0]        j;
    logic [RW-1:0]        rot;
    logic signed [LW:0]   m;
    logic                 sgn;
    logic                 m_pos, m_neg, dis;
    logic [LW:0]          mag;
    logic [N-1:0]         beats;
    logic [2*N-1:0]       fo_next;
    logic                 lvl_bad;
    logic                 start;

    assign lvl_bad = (vc_level > LMAX);
    assign start   = (state == IDLE) && period_flag && !lvl_bad;
    assign m_neg   = m[LW];
    assign m_pos   = !m[LW] && (m != '0);
    assign dis     = m_pos ^ sgn;
    assign mag     = m_neg ? (-m) : m;

    // Tie-break key: a cell's distance from the current rotation origin.
    function automatic int key_of(input int x, input logic [RW-1:0] r);
        int rr;
        rr = int'(r);
        return (x >= rr) ? (x - rr) : (x + N - rr);
    endfunction

    // State register.
    // NOTE: registers use non-blocking (<=) so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: start on a valid strobe, rank for N cycles, then apply.
    // NOTE: default assignment first, so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RANK;
            RANK:    if (j == LAST) state_next = APPLY;
            APPLY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: busy for the whole update, including the APPLY cycle.
    always_comb begin
        busy = (state != IDLE);
    end

    // Voltage snapshot, taken only when an update starts.
    // NOTE: the snapshot array is deliberately left out of reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (start) begin
            for (int i = 0; i < N; i++) vs[i] <= vc_flat[i*VW +: VW];
        end
    end

    // Pivot comparison: beats[i] is set when pivot j precedes cell i.
    always_comb begin
        beats = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(j) != i) begin
                if (dis ? (vs[j] > vs[i]) : (vs[j] < vs[i]))
                    beats[i] = 1'b1;
                else if ((vs[j] == vs[i]) && (key_of(int'(j), rot) < key_of(i, rot)))
                    beats[i] = 1'b1;
            end
        end
    end

    // Gate code selection from the final ranks and the latched level.
    always_comb begin
        fo_next = '0;
        for (int i = 0; i < N; i++) begin
            if (m_pos && ((LW+1)'(rank[i]) < mag))      fo_next[2*i +: 2] = 2'b10;
            else if (m_neg && ((LW+1)'(rank[i]) < mag)) fo_next[2*i +: 2] = 2'b01;
        end
    end

    // Control datapath: level latch, rank accumulation, outputs and pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            fo      <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            overrun <= 1'b0;
            rot     <= '0;
            j       <= '0;
            m       <= '0;
            sgn     <= 1'b0;
            for (int i = 0; i < N; i++) rank[i] <= '0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (period_flag) begin
                        if (lvl_bad) begin
                            err <= 1'b1;
                        end else begin
                            m   <= $signed({1'b0, vc_level}) - N_S;
                            sgn <= sign_i;
                            j   <= '0;
                            for (int i = 0; i < N; i++) rank[i] <= '0;
                        end
                    end
                end
                RANK: begin
                    overrun <= period_flag;
                    for (int i = 0; i < N; i++) rank[i] <= rank[i] + RW'(beats[i]);
                    j <= j + 1'b1;
                end
                APPLY: begin
                    overrun <= period_flag;
                    fo      <= fo_next;
                    done    <= 1'b1;
                    rot     <= (rot == LAST) ? '0 : rot + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_balance_n.sv
// Directed bench for arm_balance_n at N=4, VW=8: reset state, discharge and
// charge selection, negative and zero levels, tie rotation, level error,
// overrun while busy and reset in the middle of an update.
module tb_arm_balance_n;

    localparam int N  = 4;
    localparam int VW = 8;
    localparam int LW = $clog2(2*N+1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            period_flag = 1'b0;
    logic            sign_i = 1'b0;
    logic [LW-1:0]   vc_level = '0;
    logic [N*VW-1:0] vc_flat = '0;
    logic [2*N-1:0]  fo;
    logic            busy, done, err, overrun;

    int total = 0;
    int bad   = 0;
    logic [7:0] fo_prev = 8'h00;

    arm_balance_n #(.N(N), .VW(VW)) dut (
        .clk(clk), .rst(rst), .period_flag(period_flag), .sign_i(sign_i),
        .vc_level(vc_level), .vc_flat(vc_flat), .fo(fo), .busy(busy),
        .done(done), .err(err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Voltages listed cell0..cell3.
    function automatic logic [31:0] pack(input int v0, input int v1, input int v2, input int v3);
        return {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
    endfunction

    // One full update: strobe at edge T, then disturb the inputs during RANK.
    task automatic run_update(input logic [31:0] vc, input logic [LW-1:0] lvl,
                              input logic s, input logic [7:0] exp, input string tag);
        @(negedge clk);
        vc_flat = vc; vc_level = lvl; sign_i = s; period_flag = 1'b1;
        @(negedge clk);
        period_flag = 1'b0; vc_flat = ~vc; sign_i = ~s;
        check({tag, "_busy_T"}, busy, 1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        check({tag, "_busy_T4"}, busy, 1);
        check({tag, "_done_T4"}, done, 0);
        check({tag, "_fo_hold"}, fo, fo_prev);
        @(negedge clk);
        check({tag, "_fo"}, fo, exp);
        check({tag, "_done"}, done, 1);
        check({tag, "_idle"}, busy, 0);
        fo_prev = exp;
        @(negedge clk);
        check({tag, "_done_clr"}, done, 0);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_fo", fo, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ovr", overrun, 0);
        repeat (3) @(negedge clk);
        check("rst_quiet_fo", fo, 8'h00);
        check("rst_quiet_busy", busy, 0);

        // Discharge / charge / negative / zero level
        run_update(pack(10, 40, 30, 20), 4'd6, 1'b0, 8'h28, "dis");
        run_update(pack(10, 40, 30, 20), 4'd6, 1'b1, 8'h82, "chg");

        // Level error: fo held at 82h
        @(negedge clk);
        vc_level = 4'd9; period_flag = 1'b1;
        @(negedge clk);
        period_flag = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_fo", fo, 8'h82);
        @(negedge clk);
        check("err_clr", err, 0);
        check("err_busy2", busy, 0);

        run_update(pack(10, 40, 30, 20), 4'd1, 1'b0, 8'h51, "neg");
        run_update(pack(10, 40, 30, 20), 4'd4, 1'b0, 8'h00, "zero");

        // Overrun: second strobe at T+2, first update still completes at T+5
        @(negedge clk);
        vc_flat = pack(10, 40, 30, 20); vc_level = 4'd6; sign_i = 1'b0; period_flag = 1'b1;
        @(negedge clk);
        period_flag = 1'b0;
        @(negedge clk);
        period_flag = 1'b1; vc_level = 4'd2;
        @(negedge clk);
        period_flag = 1'b0;
        check("ovr_pulse", overrun, 1);
        check("ovr_busy", busy, 1);
        @(negedge clk);
        check("ovr_clr", overrun, 0);
        @(negedge clk);
        check("ovr_fo_hold", fo, 8'h00);
        @(negedge clk);
        check("ovr_fo", fo, 8'h28);
        check("ovr_done", done, 1);
        check("ovr_idle", busy, 0);
        fo_prev = 8'h28;

        // Reset at T+3 aborts the update
        @(negedge clk);
        vc_flat = pack(10, 40, 30, 20); vc_level = 4'd6; sign_i = 1'b1; period_flag = 1'b1;
        @(negedge clk);
        period_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_fo", fo, 8'h00);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        check("abort_fo_after", fo, 8'h00);
        fo_prev = 8'h00;

        // Tie rotation from rot=0
        for (int k = 0; k < 4; k++)
            run_update(pack(50, 50, 50, 50), 4'd5, 1'b0, 8'(2 << (2*k)), $sformatf("tie%0d", k));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arm_balance_n.md
Name: arm_balance_n

Overview:
- Parametrised N-cell successor to the two-cell arm balancer for a modular multilevel converter arm built from full-bridge cells.
- On each modulation period it snapshots all cell capacitor voltages and ranks them sequentially, one pivot per cycle.
- From the requested arm level and the arm current sign, it picks which cells to insert (positive or negative) and which to bypass.
- Adds equal-voltage rotation, level range checking and overrun detection.

Parameters:
- N, 4, number of full-bridge cells in the arm (2..16).
- VW, 8, capacitor voltage sample width (unsigned).
- LW, $clog2(2*N+1), width of vc_level.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- period_flag  in  1  one-cycle strobe that starts an update.
- sign_i  in  1  arm current sign: 0 = positive insertion discharges the cell, 1 = positive insertion charges it.
- vc_level  in  LW  requested arm level, 0..2N; signed level m = vc_level - N.
- vc_flat  in  N*VW  cell voltages; cell i occupies [i*VW +: VW].
- fo  out  2N  gate code per cell, fo[2i+1:2i]: 10 = +vc, 01 = -vc, 00 = bypass.
- busy  out  1  high while an update is in progress.
- done  out  1  one-cycle pulse when fo is updated.
- err  out  1  one-cycle pulse when vc_level > 2N.
- overrun  out  1  one-cycle pulse when period_flag arrives while busy.

Behaviour:
- Reset: fo=0 (all bypass), busy=0, done=0, err=0, overrun=0, rot=0, FSM=IDLE. Reset mid-update aborts the update; fo returns to 0.
- FSM states: IDLE, RANK, APPLY.
- IDLE, period_flag=1 at edge T:
  - vc_level > 2N: err pulses at T, no state change, fo held.
  - otherwise: latch vc_flat, sign_i and m; clear rank_i for all cells; j=0; go to RANK; busy=1 from T.
- RANK (edges T+1..T+N): each cycle compare every cell i against pivot j in parallel:
  - if j != i and j precedes i, then rank_i += 1; then j += 1.
  - After j = N-1, go to APPLY.
- Precedence:
  - dis = (m>0) XOR sign_i.
  - j precedes i if (dis ? vj > vi : vj < vi), or vj == vi and key(j) < key(i), with key(x) = (x - rot) mod N.
  - Ranks are therefore a permutation of 0..N-1. Rank 0 is the highest voltage when discharging and the lowest when charging.
- APPLY (edge T+N+1):
  - cell i gets 10 if m>0 and rank_i < m; 01 if m<0 and rank_i < -m; else 00.
  - m=0 gives all 00.
  - done pulses; rot = (rot+1) mod N; busy=0; return to IDLE.
- Latency: fo changes exactly N+1 cycles after the period_flag edge; fo is held constant between updates.
- period_flag while busy: ignored, overrun pulses that cycle, the running update is unaffected.
- period_flag on the APPLY cycle is also treated as overrun.
- Arithmetic: comparisons are unsigned on VW bits; rank counters are $clog2(N) bits; the m magnitude is computed in LW+1-bit signed.
- Voltages are read only from the snapshot; vc_flat changes during RANK have no effect.

Test Plan (N=4, VW=8; voltages listed cell0..cell3):
- Reset: hold rst 3 cycles, then release -> fo=8'h00, busy=0, done=0; no output change without period_flag.
- Discharge pick: vc={10,40,30,20}, vc_level=6 (m=+2), sign_i=0, strobe at T -> busy at T..T+4, fo=8'b00_10_10_00 and done pulse at T+5.
- Charge pick: same voltages and level, sign_i=1 -> fo=8'b10_00_00_10 (cells 0 and 3 inserted positive).
- Negative level: vc={10,40,30,20}, vc_level=1 (m=-3), sign_i=0 -> fo=8'b01_01_00_01; then vc_level=4 -> fo=8'h00.
- Tie rotation: all cells 50, vc_level=5, sign_i=0, four consecutive periods starting rot=0 -> inserted cell is 0, 1, 2, 3; fo = 02h, 08h, 20h, 80h.
- Errors:
  - vc_level=9 -> err pulse, fo unchanged, busy stays 0.
  - Second period_flag at T+2 -> overrun pulse at T+2; the first update completes normally at T+5.
  - rst at T+3 -> fo=0, busy=0, no done pulse.
